pipe_sum_accumulator: RTL
=========================

// Module: pipe_sum_accumulator
// PURPOSE
//  Downstream consumer of the 2-stage pipelined 26-bit adder (27-bit sum, 3-cycle latency).
//  - Tracks operand validity through a delay line matched to the adder latency.
//  - Accumulates COUNT adder results into one ACC_W-bit batch total.
//  - Presents the total on a valid/ready output and throttles operand issue so no in-flight result is lost.
// PARAMETERS
//  SUM_W    27  width of adder sum_output
//  ACC_W    32  accumulator width; must be >= SUM_W
//  COUNT    8   adder results per batch; range 1..255
//  LATENCY  3   operand-to-sum latency of the adder, in clocks
// PORTS
//  clk        in   1      single clock, rising edge
//  reset      in   1      synchronous, active-high
//  op_valid   in   1      operands driven onto the adder a/b/c_in this cycle
//  op_ready   out  1      upstream may issue operands; issue = op_valid & op_ready
//  sum_in     in   SUM_W  adder sum_output
//  out_valid  out  1      acc_out holds a completed batch total
//  out_ready  in   1      consumer accepts the total
//  acc_out    out  ACC_W  batch total
//  ovf        out  1      sticky overflow flag for the current batch
// BEHAVIOUR
//  - Reset (sync, high): state=ACCUM, acc_out=0, out_valid=0, ovf=0, op_ready=1,
//    issue/receive counters=0, valid delay line=0.
//  - Adder reset: the adder's own reset is active-low; the parent ties it to ~reset.
//  - Delay line: a LATENCY-deep shift register of issue.
//    - Issue in cycle t marks sum_in valid in cycle t+LATENCY (sum_vld).
//    - Bubbles in op_valid are allowed; every issue produces exactly one accumulate.
//  - FSM state ACCUM:
//    - op_ready = (iss_cnt < COUNT). Each issue increments iss_cnt.
//    - op_valid while op_ready=0 is ignored: no issue, no count.
//    - When sum_vld=1: acc <= acc + zero-extended sum_in; rcv_cnt++.
//    - When the accumulate brings rcv_cnt to COUNT: go to HOLD next cycle.
//  - FSM state HOLD:
//    - out_valid=1, op_ready=0. acc_out and ovf are held stable.
//    - On out_valid & out_ready: next cycle acc=0, ovf=0, counters=0, state=ACCUM, op_ready=1.
//  - No results can arrive in HOLD: issue stops at COUNT.
//    A sum_vld seen in HOLD is a design error; cover it with an assertion.
//  - Latency: the last issue occurs in cycle t; out_valid rises in cycle t+LATENCY+1.
//  - ACCUM -> HOLD costs no bubble.
//    The next batch's first issue occurs in the cycle after acceptance.
//  - Overflow: a carry out of bit ACC_W-1 on any accumulate sets ovf.
//    ovf stays set until the batch is accepted or reset.
//  - Reset mid-batch: the delay line is cleared, so in-flight adder results are discarded.
//    Partial acc is dropped; no out_valid is produced for the aborted batch.
//  - COUNT=1: the batch completes on the single result; HOLD is entered the next cycle.
// CONFIGURATION
//  ACC_SAT_EN
//  - Defined: saturating accumulation. On carry-out, acc <= all ones and ovf is set.
//    Further adds keep all ones.
//  - Undefined: acc wraps modulo 2^ACC_W; ovf is still set.
// TESTING
//  1. Defaults; issue a=1..8, b=0, c_in=0 in cycles 0..7; out_ready=1
//     -> out_valid=1 in cycle 11 only; acc_out=36; ovf=0; op_ready=0 in cycles 8..11, 1 in cycle 12.
//  2. Same as 1 with out_ready=0 for cycles 11..15, 1 in cycle 16
//     -> acc_out=36 and out_valid=1 stable in cycles 11..16; op_ready=0 until cycle 17.
//  3. Defaults; issue on alternate cycles, a=b=0x1000, c_in=1, 8 issues
//     -> acc_out = 8*0x2001 = 0x10008 after the last sum; no op_valid ignored while op_ready=1.
//  4. ACC_W=27, COUNT=2; two issues a=b=0x2000000, c_in=0 (sum 0x4000000)
//     -> ovf=1; acc_out=0x0000000 without ACC_SAT_EN; acc_out=0x7FFFFFF with ACC_SAT_EN.
//  5. Defaults; issue 3 operands in cycles 0..2; reset=1 in cycle 3; resume issuing 8 x a=2 from cycle 5
//     -> pre-reset sums are never accumulated; acc_out=16; out_valid not asserted before that batch.
//  6. Defaults; hold op_valid=1 continuously for 20 cycles with a=5
//     -> exactly 8 issues per batch; each batch acc_out=40; ignored cycles have no effect.

Source files
------------

// File: rtl/pipe_sum_accumulator.sv
// pipe_sum_accumulator: consumes sums from a 3-cycle pipelined adder and
// accumulates COUNT results into one batch total. The total is offered on a
// valid/ready output. Operand issue is throttled so that no in-flight sum is
// ever dropped.
// Optional build macro: ACC_SAT_EN. When defined, a carry out clamps the
// accumulator to all ones. When undefined, the accumulator wraps. ovf is set
// in both cases.
module pipe_sum_accumulator #(
  parameter int SUM_W   = 27,
  parameter int ACC_W   = 32,
  parameter int COUNT   = 8,
  parameter int LATENCY = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [SUM_W-1:0] sum_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             ovf
);

  localparam int CNT_W = $clog2(COUNT + 1);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(COUNT - 1);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t             state;
  logic [CNT_W-1:0]   iss_cnt;
  logic [CNT_W-1:0]   rcv_cnt;
  logic [LATENCY-1:0] vld_p;
  logic               issue;
  logic               sum_vld;
  logic [ACC_W:0]     acc_nxt;

  // Adds a zero-extended sum to the accumulator.
  // Bit ACC_W of the result carries the overflow indication.
  function automatic logic [ACC_W:0] acc_add(input logic [ACC_W-1:0] acc,
                                             input logic [SUM_W-1:0] s);
    logic [ACC_W:0] raw;
    raw = {1'b0, acc} + {1'b0, ACC_W'(s)};
`ifdef ACC_SAT_EN
    if (raw[ACC_W]) raw[ACC_W-1:0] = '1;
`endif
    return raw;
  endfunction

  assign issue   = op_valid & op_ready;
  assign sum_vld = vld_p[LATENCY-1];
  assign acc_nxt = acc_add(acc_out, sum_in);

  // Issue -> sum-valid delay line, batch FSM, counters and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ACCUM;
      acc_out   <= '0;
      out_valid <= 1'b0;
      ovf       <= 1'b0;
      op_ready  <= 1'b1;
      iss_cnt   <= '0;
      rcv_cnt   <= '0;
      vld_p     <= '0;
    end else begin
      // delay-line stage boundary: issue in cycle t marks sum_in valid in t+LATENCY
      vld_p[0] <= issue;
      for (int i = 1; i < LATENCY; i++) vld_p[i] <= vld_p[i-1];

      case (state)
        ACCUM: begin
          if (issue) begin
            iss_cnt <= iss_cnt + CNT_W'(1);
            // The final issue of the batch closes the gate on the next cycle
            if (iss_cnt == LAST_C) op_ready <= 1'b0;
          end
          if (sum_vld) begin
            acc_out <= acc_nxt[ACC_W-1:0];
            if (acc_nxt[ACC_W]) ovf <= 1'b1;
            rcv_cnt <= rcv_cnt + CNT_W'(1);
            if (rcv_cnt == LAST_C) begin
              state     <= HOLD;
              out_valid <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= ACCUM;
            out_valid <= 1'b0;
            acc_out   <= '0;
            ovf       <= 1'b0;
            iss_cnt   <= '0;
            rcv_cnt   <= '0;
            op_ready  <= 1'b1;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

  // Issue stops at COUNT, so a sum can never land while a total is held
  a_no_sum_in_hold: assert property (@(posedge clk) disable iff (reset)
                                     !(state == HOLD && sum_vld));

endmodule
